// File: rtl/schedule_hazard.sv
// schedule_hazard: per-register pending-write scoreboard for x1..x31.
// It raises a combinational stall when the candidate instruction reads a
// register with an outstanding write, or when issuing it would overflow the
// destination register's pending-write counter.
module schedule_hazard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FLUSH,
    input  logic       MEM_WAIT,
    input  logic [6:0] DECODE_2ND_OPCODE,
    input  logic [4:0] DECODE_2ND_RS1,
    input  logic [4:0] DECODE_2ND_RS2,
    input  logic [4:0] DECODE_2ND_RD,
    input  logic       WB_REG_W_EN,
    input  logic [4:0] WB_REG_W_RD,
    output logic       STALL,
    output logic       SCHEDULE_HAZARD_BUSY
);

    localparam int unsigned NUM_REGS = 32;
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Entry 0 exists only so register indices map directly; it stays zero.
    logic [CNT_W-1:0] r_cnt     [NUM_REGS];
    logic [CNT_W-1:0] w_cnt_nxt [NUM_REGS];
    logic             r_busy;

    logic w_reads_rs1;
    logic w_reads_rs2;
    logic w_writes_rd;
    logic w_h1;
    logic w_h2;
    logic w_hsat;
    logic w_stall;
    logic w_iss;
    logic w_ret;
    logic w_busy_nxt;

    // Opcode class decode: which operand fields the candidate actually uses.
    always_comb begin
        w_reads_rs1 = 1'b0;
        w_reads_rs2 = 1'b0;
        w_writes_rd = 1'b0;
        case (DECODE_2ND_OPCODE)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                w_writes_rd = 1'b1;
            end
            OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM: begin
                w_writes_rd = 1'b1;
                w_reads_rs1 = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                w_reads_rs1 = 1'b1;
                w_reads_rs2 = 1'b1;
            end
            OP_OP: begin
                w_writes_rd = 1'b1;
                w_reads_rs1 = 1'b1;
                w_reads_rs2 = 1'b1;
            end
            default: begin
                w_writes_rd = 1'b0;
            end
        endcase
    end

    // Hazard detection against registered state only (no writeback bypass).
    always_comb begin
        w_h1    = w_reads_rs1 && (DECODE_2ND_RS1 != 5'd0) && (r_cnt[DECODE_2ND_RS1] != '0);
        w_h2    = w_reads_rs2 && (DECODE_2ND_RS2 != 5'd0) && (r_cnt[DECODE_2ND_RS2] != '0);
        w_hsat  = w_writes_rd && (DECODE_2ND_RD != 5'd0) && (r_cnt[DECODE_2ND_RD] == CNT_SAT);
        w_stall = !RST && !FLUSH && (w_h1 || w_h2 || w_hsat);
        w_iss   = w_writes_rd && (DECODE_2ND_RD != 5'd0) && !w_stall && !MEM_WAIT && !FLUSH && !RST;
        w_ret   = WB_REG_W_EN && (WB_REG_W_RD != 5'd0) && !FLUSH && !RST;
    end

    // Per-register next count: issue increments, retire decrements, both cancel.
    always_comb begin
        w_busy_nxt = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (i == 0) begin
                w_cnt_nxt[i] = '0;
            end else begin
                if (w_iss && (DECODE_2ND_RD == 5'(i)) &&
                    !(w_ret && (WB_REG_W_RD == 5'(i)))) begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end else if (w_ret && (WB_REG_W_RD == 5'(i)) &&
                             !(w_iss && (DECODE_2ND_RD == 5'(i))) &&
                             (r_cnt[i] != '0)) begin
                    w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
                end
            end
            w_busy_nxt = w_busy_nxt | (w_cnt_nxt[i] != '0);
        end
    end

    // Counter and busy registers; reset and flush both wipe the board.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= '0;
            end
            r_busy <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign STALL                = w_stall;
    assign SCHEDULE_HAZARD_BUSY = r_busy;

endmodule

// File: tb/tb_schedule_hazard.sv
// Testbench for schedule_hazard: directed scenarios followed by random
// traffic, all compared against a simple pending-write count model.
module tb_schedule_hazard;

    localparam int CNT_W = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic       CLK;
    logic       RST;
    logic       FLUSH;
    logic       MEM_WAIT;
    logic [6:0] OP;
    logic [4:0] RS1;
    logic [4:0] RS2;
    logic [4:0] RD;
    logic       WEN;
    logic [4:0] WRD;
    logic       STALL;
    logic       BUSY;

    int n_checks;
    int n_errors;
    int m_cnt [32];

    logic [6:0] op_pool [12] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                 7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b1110011, 7'b0000000, 7'b0001111};

    schedule_hazard #(.CNT_W(CNT_W)) dut (
        .CLK                  (CLK),
        .RST                  (RST),
        .FLUSH                (FLUSH),
        .MEM_WAIT             (MEM_WAIT),
        .DECODE_2ND_OPCODE    (OP),
        .DECODE_2ND_RS1       (RS1),
        .DECODE_2ND_RS2       (RS2),
        .DECODE_2ND_RD        (RD),
        .WB_REG_W_EN          (WEN),
        .WB_REG_W_RD          (WRD),
        .STALL                (STALL),
        .SCHEDULE_HAZARD_BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit op_writes(input logic [6:0] op);
        return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                          7'b0000011, 7'b0010011, 7'b0110011, 7'b1110011};
    endfunction

    function automatic bit op_reads1(input logic [6:0] op);
        return op inside {7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                          7'b0010011, 7'b0110011, 7'b1110011};
    endfunction

    function automatic bit op_reads2(input logic [6:0] op);
        return op inside {7'b1100011, 7'b0100011, 7'b0110011};
    endfunction

    // Expected stall from the model board and the currently driven inputs.
    function automatic bit m_stall();
        bit h;
        if (RST || FLUSH) return 1'b0;
        h = 1'b0;
        if (op_reads1(OP) && RS1 != 0 && m_cnt[RS1] > 0) h = 1'b1;
        if (op_reads2(OP) && RS2 != 0 && m_cnt[RS2] > 0) h = 1'b1;
        if (op_writes(OP) && RD != 0 && m_cnt[RD] == SAT) h = 1'b1;
        return h;
    endfunction

    function automatic bit m_busy();
        for (int i = 0; i < 32; i++) if (m_cnt[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs and compare STALL with the model.
    task automatic drv(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wen, input logic [4:0] wrd,
                       input logic fl, input logic mw, input logic rs);
        OP = op; RS1 = rs1; RS2 = rs2; RD = rd;
        WEN = wen; WRD = wrd; FLUSH = fl; MEM_WAIT = mw; RST = rs;
        #1;
        chk("stall", STALL, m_stall());
    endtask

    // Clock edge: advance the model, then compare BUSY.
    task automatic tick();
        bit s;
        bit iss;
        bit ret;
        s = m_stall();
        @(posedge CLK);
        if (RST || FLUSH) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        end else begin
            iss = op_writes(OP) && RD != 0 && !s && !MEM_WAIT;
            ret = WEN && WRD != 0;
            if (!(iss && ret && RD == WRD)) begin
                if (iss) m_cnt[RD] = m_cnt[RD] + 1;
                if (ret && m_cnt[WRD] > 0) m_cnt[WRD] = m_cnt[WRD] - 1;
            end
        end
        #1;
        chk("busy", BUSY, m_busy());
    endtask

    task automatic do_reset();
        drv(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
            1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        chk("rst_stall", STALL, 1'b0);
        tick();
        chk("rst_busy", BUSY, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;

        // Reset with random inputs, then one instruction on an empty board
        do_reset();
        do_reset();
        drv(7'b0110011, 5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("empty_issue", STALL, 1'b0);
        tick();
        chk("busy_after_issue", BUSY, 1'b1);
        drv(7'b1100011, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x3_pending", STALL, 1'b1);
        tick();

        // RAW stall and release
        do_reset();
        drv(7'b0010011, 5'd0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0110011, 5'd5, 5'd0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("raw_stall", STALL, 1'b1);
        tick();
        drv(7'b0110011, 5'd5, 5'd0, 5'd6, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("raw_wb_same_cycle", STALL, 1'b1);
        tick();
        drv(7'b0110011, 5'd5, 5'd0, 5'd6, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("raw_release", STALL, 1'b0);
        tick();
        drv(7'b1100011, 5'd6, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x6_pending", STALL, 1'b1);
        tick();

        // Saturation of x7
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drv(7'b0010011, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
            chk("sat_fill", STALL, 1'b0);
            tick();
        end
        drv(7'b0010011, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_stall", STALL, 1'b1);
        tick();
        drv(7'b0010011, 5'd0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("sat_stall_wb", STALL, 1'b1);
        tick();
        drv(7'b0010011, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_release", STALL, 1'b0);
        tick();
        drv(7'b0010011, 5'd0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("sat_again", STALL, 1'b1);
        tick();

        // Simultaneous issue and retire, same and different registers
        do_reset();
        drv(7'b0010011, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0000011, 5'd0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        chk("same_reg_issue", STALL, 1'b0);
        tick();
        drv(7'b1100011, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x9_still_pending", STALL, 1'b1);
        tick();
        do_reset();
        drv(7'b0010011, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0000011, 5'd0, 5'd0, 5'd10, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b1100011, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x9_cleared", STALL, 1'b0);
        tick();
        drv(7'b1100011, 5'd0, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("x10_pending", STALL, 1'b1);
        tick();

        // Flush discards issue/retire and clears the board
        do_reset();
        drv(7'b0010011, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0010011, 5'd0, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0010011, 5'd0, 5'd0, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0110011, 5'd4, 5'd8, 5'd12, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("flush_stall_low", STALL, 1'b0);
        tick();
        chk("flush_busy", BUSY, 1'b0);
        drv(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stray_wb_busy", BUSY, 1'b0);

        // Non-reading opcodes, x0 and MEM_WAIT
        drv(7'b1100011, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("branch_x0", STALL, 1'b0);
        tick();
        drv(7'b0110111, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lui_x0_busy", BUSY, 1'b0);
        drv(7'b0010011, 5'd0, 5'd0, 5'd13, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("memwait_busy", BUSY, 1'b0);
        drv(7'b0010011, 5'd0, 5'd0, 5'd11, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drv(7'b0100011, 5'd0, 5'd11, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("store_rs2", STALL, 1'b1);
        tick();

        // Random traffic on a small register window to provoke hazards
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            drv(op_pool[$urandom_range(0, 11)],
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 199) == 0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
